// File: rtl/pc_sequencer_if.sv
// Memory-side handshake bundle for the PC sequencer: instruction fetch and
// data access request/ack pairs plus the fetched instruction word.
interface pc_sequencer_if #(
  parameter int DWIDTH = 32
);
  logic              imem_req;
  logic              imem_ack;
  logic [DWIDTH-1:0] instr_in;
  logic              dmem_req;
  logic              dmem_ack;

  modport master (
    output imem_req, dmem_req,
    input  imem_ack, instr_in, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req,
    output imem_ack, instr_in, dmem_ack
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM for an RV32I-subset core: fetch, decode, execute,
// write-back, with one pc_en strobe per retired instruction.
module pc_sequencer #(
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  pc_sequencer_if.master    mem,
  input  logic              halt_req,
  output logic              ir_en,
  output logic              pc_en,
  output logic [1:0]        pc_select,
  output logic              rf_we,
  output logic              halted,
  output logic              illegal_instr,
  output logic              bus_error,
  output logic [DWIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       wr;
    logic       mem_op;
    logic [1:0] sel;
  } dec_t;

  localparam logic [7:0] CNT_LIM = 8'(TIMEOUT - 1);

  function automatic dec_t decode(input logic [6:0] op);
    dec_t d;
    d = '{legal: 1'b1, wr: 1'b1, mem_op: 1'b0, sel: 2'b00};
    case (op)
      7'b1101111: d.sel = 2'b10;
      7'b1100111: d.sel = 2'b11;
      7'b1100011: begin d.sel = 2'b01; d.wr = 1'b0; end
      7'b0000011: d.mem_op = 1'b1;
      7'b0100011: begin d.mem_op = 1'b1; d.wr = 1'b0; end
      7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: ;
      default:    d = '{legal: 1'b0, wr: 1'b0, mem_op: 1'b0, sel: 2'b00};
    endcase
    return d;
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic              wr_q, wr_d;
  logic              mop_q, mop_d;
  logic              ill_q, ill_d;
  logic              berr_q, berr_d;
  logic [DWIDTH-1:0] instret_q, instret_d;

  dec_t dec;
  logic ack_wait;
  logic tmo;

  // Only the opcode field drives decode; the rest of the word belongs to the IR.
  logic unused_instr;
  assign unused_instr = ^mem.instr_in;

  assign dec = decode(mem.instr_in[6:0]);

  // A pending ack that has waited the full budget without arriving.
  assign ack_wait = ((state_q == S_FETCH) && !mem.imem_ack) ||
                    ((state_q == S_EXEC) && mop_q && !mem.dmem_ack);
  assign tmo      = ack_wait && (cnt_q == CNT_LIM);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (mem.imem_ack) state_d = S_DECODE;
                else if (tmo)     state_d = S_HALT;
      S_DECODE: state_d = dec.legal ? S_EXEC : S_HALT;
      S_EXEC:   if (!mop_q || mem.dmem_ack) state_d = S_WB;
                else if (tmo)               state_d = S_HALT;
      S_WB:     state_d = halt_req ? S_HALT : S_FETCH;
      S_HALT:   if (!ill_q && !berr_q && !halt_req) state_d = S_FETCH;
      default:  state_d = S_RST;
    endcase
  end

  // Outputs are pure state decodes, apart from ir_en following the fetch ack.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    rf_we        = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        ir_en        = mem.imem_ack;
      end
      S_EXEC:  mem.dmem_req = mop_q;
      S_WB: begin
        pc_en = 1'b1;
        rf_we = wr_q;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers: wait counter, decoded class, sticky errors, retire count.
  always_comb begin
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    wr_d      = wr_q;
    mop_d     = mop_q;
    ill_d     = ill_q;
    berr_d    = berr_q | tmo;
    instret_d = instret_q;

    // Every state change restarts the wait budget, covering entry to FETCH/EXEC.
    if (state_d != state_q) cnt_d = '0;
    else if (ack_wait)      cnt_d = cnt_q + 8'd1;

    if (state_q == S_DECODE) begin
      if (dec.legal) begin
        sel_d = dec.sel;
        wr_d  = dec.wr;
        mop_d = dec.mem_op;
      end else begin
        ill_d = 1'b1;
      end
    end

    if (state_q == S_WB) instret_d = instret_q + DWIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      sel_q     <= 2'b00;
      wr_q      <= 1'b0;
      mop_q     <= 1'b0;
      ill_q     <= 1'b0;
      berr_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      wr_q      <= wr_d;
      mop_q     <= mop_d;
      ill_q     <= ill_d;
      berr_q    <= berr_d;
      instret_q <= instret_d;
    end
  end

  assign pc_select     = sel_q;
  assign illegal_instr = ill_q;
  assign bus_error     = berr_q;
  assign instret       = instret_q;

  a_req_excl: assert property (@(posedge clk) disable iff (reset)
    !(mem.imem_req && mem.dmem_req));

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: cycle-by-cycle checks of the control strobes
// across instruction classes, ack delays, timeouts, halt and reset.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        halt_req;
  logic        ir_en, pc_en, rf_we, halted, illegal_instr, bus_error;
  logic [1:0]  pc_select;
  logic [31:0] instret;

  int n_chk = 0;
  int n_err = 0;

  pc_sequencer_if #(.DWIDTH(32)) mem_if ();

  pc_sequencer #(.DWIDTH(32), .TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem          (mem_if),
    .halt_req     (halt_req),
    .ir_en        (ir_en),
    .pc_en        (pc_en),
    .pc_select    (pc_select),
    .rf_we        (rf_we),
    .halted       (halted),
    .illegal_instr(illegal_instr),
    .bus_error    (bus_error),
    .instret      (instret)
  );

  // {imem_req, ir_en, dmem_req, pc_en, rf_we, halted}
  wire [5:0] outs = {mem_if.imem_req, ir_en, mem_if.dmem_req, pc_en, rf_we, halted};

  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_BR  = 7'b1100011, OP_LD   = 7'b0000011,
                         OP_ST  = 7'b0100011, OP_LUI  = 7'b0110111,
                         OP_AUI = 7'b0010111, OP_ADDI = 7'b0010011,
                         OP_OR  = 7'b0110011, OP_SYS  = 7'b1110011;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next active edge; inputs are then set and
  // outputs checked #1 later, well clear of either clock edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Runs one instruction starting at its FETCH cycle, checking every cycle.
  task automatic run_instr(input string tag, input logic [6:0] op, input int ilat,
                           input int dlat, input logic [1:0] sel, input logic wr,
                           input logic mop, input logic hlt);
    mem_if.instr_in = {25'h1234567, op};
    for (int i = 0; i <= ilat; i++) begin
      mem_if.imem_ack = (i == ilat);
      #1 chk({tag, " fetch"}, 32'(outs), {26'd0, 1'b1, (i == ilat), 4'b0000});
      step();
    end
    mem_if.imem_ack = 1'b0;
    #1 chk({tag, " decode"}, 32'(outs), 32'd0);
    step();
    halt_req = hlt;
    if (mop) begin
      for (int i = 0; i <= dlat; i++) begin
        mem_if.dmem_ack = (i == dlat);
        #1 chk({tag, " exec"}, 32'(outs), 32'b001000);
        step();
      end
      mem_if.dmem_ack = 1'b0;
    end else begin
      #1 chk({tag, " exec"}, 32'(outs), 32'd0);
      step();
    end
    #1 chk({tag, " wb"}, 32'(outs), {28'd0, 1'b1, wr, 1'b0});
    chk({tag, " sel"}, 32'(pc_select), 32'(sel));
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1 chk("reset outs", {20'd0, outs, pc_select, illegal_instr, bus_error}, 32'd0);
    chk("reset instret", instret, 32'd0);
    step();
    reset = 1'b0;
    #1 chk("rst cycle", 32'(outs), 32'd0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    halt_req = 1'b0;
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    mem_if.instr_in = '0;
    step();
    do_reset();

    // Back-to-back ADDI with immediate acks: retire every 4th cycle.
    for (int k = 0; k < 3; k++) run_instr("addi", OP_ADDI, 0, 0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("instret after 3 addi", instret, 32'd3);

    run_instr("jal",  OP_JAL,  0, 0, 2'b10, 1'b1, 1'b0, 1'b0);
    run_instr("br",   OP_BR,   0, 0, 2'b01, 1'b0, 1'b0, 1'b0);
    run_instr("jalr", OP_JALR, 0, 0, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("instret after ctl", instret, 32'd6);

    run_instr("load",  OP_LD,  0, 3,  2'b00, 1'b1, 1'b1, 1'b0);
    run_instr("store", OP_ST,  0, 3,  2'b00, 1'b0, 1'b1, 1'b0);
    run_instr("lui",   OP_LUI, 2, 0,  2'b00, 1'b1, 1'b0, 1'b0);
    run_instr("auipc ack@limit", OP_AUI, 15, 0, 2'b00, 1'b1, 1'b0, 1'b0);
    run_instr("or",    OP_OR,  1, 0,  2'b00, 1'b1, 1'b0, 1'b0);
    run_instr("load ack@limit", OP_LD, 0, 15, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("instret after mem", instret, 32'd12);
    chk("no error flags", {30'd0, illegal_instr, bus_error}, 32'd0);

    // halt_req raised in EXEC: the ADDI still retires, then HALT until dropped.
    run_instr("addi halt", OP_ADDI, 0, 0, 2'b00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1 chk("halt held", 32'(outs), 32'b000001);
      step();
    end
    halt_req = 1'b0;
    #1 chk("halt release cycle", 32'(outs), 32'b000001);
    step();
    #1 chk("refetch after halt", 32'(outs), 32'b100000);
    chk("instret after halt", instret, 32'd13);

    // Reset pulse in the middle of a FETCH wait.
    do_reset();

    // Illegal opcode: sticky halt, pc_select keeps the last legal value.
    run_instr("jal2", OP_JAL, 0, 0, 2'b10, 1'b1, 1'b0, 1'b0);
    mem_if.instr_in = {25'h0, OP_SYS};
    mem_if.imem_ack = 1'b1;
    #1 chk("ill fetch", 32'(outs), 32'b110000);
    step();
    mem_if.imem_ack = 1'b0;
    #1 chk("ill decode", 32'(outs), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      halt_req = i[0];
      #1 chk("ill halted", {24'd0, outs, illegal_instr, bus_error}, {24'd0, 6'b000001, 2'b10});
      chk("ill pc_select", 32'(pc_select), 32'b10);
      step();
    end
    halt_req = 1'b0;
    chk("ill instret", instret, 32'd1);
    do_reset();

    // Fetch ack never arrives: 16 request cycles, then bus_error halt.
    run_instr("addi3", OP_ADDI, 0, 0, 2'b00, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      #1 chk("ifetch wait", {25'd0, outs, bus_error}, {25'd0, 6'b100000, 1'b0});
      step();
    end
    for (int i = 0; i < 3; i++) begin
      halt_req = i[0];
      #1 chk("ifetch timeout", {24'd0, outs, illegal_instr, bus_error}, {24'd0, 6'b000001, 2'b01});
      step();
    end
    halt_req = 1'b0;
    chk("timeout instret", instret, 32'd1);
    do_reset();

    // Data ack never arrives: 16 dmem_req cycles, then bus_error halt.
    mem_if.instr_in = {25'h0, OP_LD};
    mem_if.imem_ack = 1'b1;
    #1 chk("dto fetch", 32'(outs), 32'b110000);
    step();
    mem_if.imem_ack = 1'b0;
    #1 chk("dto decode", 32'(outs), 32'd0);
    step();
    for (int c = 1; c <= 16; c++) begin
      #1 chk("dmem wait", {25'd0, outs, bus_error}, {25'd0, 6'b001000, 1'b0});
      step();
    end
    #1 chk("dmem timeout", {24'd0, outs, illegal_instr, bus_error}, {24'd0, 6'b000001, 2'b01});
    chk("dmem timeout instret", instret, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
